// File: rtl/buzzer_pwm_gen_if.sv
// Control and drive signals between the music sequencer/tune decoder and the buzzer PWM generator.
// The master drives the tone request; the slave (the generator) returns the buzzer drive and status.
interface buzzer_pwm_gen_if #(
    parameter int unsigned PERIOD_W = 20,
    parameter int unsigned VOL_W    = 2
);
    logic                en;
    logic [PERIOD_W-1:0] period;
    logic [VOL_W-1:0]    volume;
    logic                buzzer;
    logic                note_active;
    logic                period_wrap;

    modport master (
        output en,
        output period,
        output volume,
        input  buzzer,
        input  note_active,
        input  period_wrap
    );

    modport slave (
        input  en,
        input  period,
        input  volume,
        output buzzer,
        output note_active,
        output period_wrap
    );
endinterface

// File: rtl/buzzer_pwm_gen.sv
// Passive-buzzer PWM generator: square/pulse wave of the requested period with a volume-selected duty.
// Period, duty and enable are only resampled at period boundaries so the waveform never glitches.
module buzzer_pwm_gen #(
    parameter int unsigned PERIOD_W = 20,
    parameter int unsigned VOL_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    buzzer_pwm_gen_if.slave       bus
);

    typedef enum logic {
        StIdle,
        StRun
    } state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic [PERIOD_W-1:0] r_cnt;
    logic [PERIOD_W-1:0] w_cnt_next;
    logic [PERIOD_W-1:0] r_period;
    logic [PERIOD_W-1:0] w_period_next;
    logic [PERIOD_W-1:0] r_duty;
    logic [PERIOD_W-1:0] w_duty_next;
    logic [PERIOD_W-1:0] w_duty_in;
    logic [PERIOD_W-1:0] w_last;
    logic [PERIOD_W-1:0] w_cnt_inc;
    logic                r_buzzer;
    logic                w_buzzer_next;
    logic                w_valid;
    logic                w_wrap;

    // Duty derived from the period value that is about to be latched.
    always_comb begin
        w_duty_in = '0;
        case (bus.volume)
            2'd3:    w_duty_in = bus.period >> 1;
            2'd2:    w_duty_in = bus.period >> 2;
            2'd1:    w_duty_in = bus.period >> 3;
            default: w_duty_in = '0;
        endcase
    end

    assign w_valid   = bus.en && (bus.period >= PERIOD_W'(2));
    assign w_last    = r_period - PERIOD_W'(1);
    assign w_cnt_inc = r_cnt + PERIOD_W'(1);
    assign w_wrap    = (r_state == StRun) && (r_cnt == w_last);

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_period_next = r_period;
        w_duty_next   = r_duty;
        w_buzzer_next = r_buzzer;
        unique case (r_state)
            StIdle: begin
                w_cnt_next    = '0;
                w_buzzer_next = 1'b0;
                if (w_valid) begin
                    w_state_next  = StRun;
                    w_period_next = bus.period;
                    w_duty_next   = w_duty_in;
                    w_buzzer_next = (w_duty_in != '0);
                end
            end
            StRun: begin
                if (w_wrap) begin
                    w_cnt_next = '0;
                    if (w_valid) begin
                        w_period_next = bus.period;
                        w_duty_next   = w_duty_in;
                        w_buzzer_next = (w_duty_in != '0);
                    end else begin
                        w_state_next  = StIdle;
                        w_buzzer_next = 1'b0;
                    end
                end else begin
                    w_cnt_next    = w_cnt_inc;
                    w_buzzer_next = (w_cnt_inc < r_duty);
                end
            end
            default: begin
                w_state_next  = StIdle;
                w_cnt_next    = '0;
                w_buzzer_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_period <= '0;
            r_duty   <= '0;
            r_buzzer <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_period <= w_period_next;
            r_duty   <= w_duty_next;
            r_buzzer <= w_buzzer_next;
        end
    end

    assign bus.buzzer      = r_buzzer;
    assign bus.note_active = (r_state == StRun);
    assign bus.period_wrap = w_wrap;

endmodule

// File: doc/buzzer_pwm_gen.md
Name: buzzer_pwm_gen

Overview:
Downstream consumer of the tune decoder. Takes the 20-bit PWM period word, in 50 MHz clock cycles per tone period, and drives the passive buzzer pin with a square/pulse wave. The duty fraction sets a coarse volume. Period and volume changes are applied only at period boundaries, so the waveform never glitches. A period word of 0 (rest) or 1 produces silence.

Parameters:
PERIOD_W, 20, width of period input and internal cycle counter
VOL_W, 2, width of volume input (fixed encoding below; must be 2)

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  synchronous, active-high reset
en  input  1  play enable from the music sequencer
period  input  PERIOD_W  tone period in clk cycles, from tune decoder; 0 = rest
volume  input  VOL_W  duty select: 3 = 1/2, 2 = 1/4, 1 = 1/8, 0 = mute
buzzer  output  1  registered buzzer drive
note_active  output  1  high while the state machine is in RUN
period_wrap  output  1  one-cycle pulse on the last cycle of each tone period

Behaviour:
- Reset (rst sampled high at clk edge): state = IDLE, cnt = 0, period_r = 0, duty_r = 0, buzzer = 0, note_active = 0, period_wrap = 0. rst has priority over every other input.
- Duty computation from volume, using the period value being latched:
  - vol 3: duty = period >> 1
  - vol 2: duty = period >> 2
  - vol 1: duty = period >> 3
  - vol 0: duty = 0
  - Truncating shift. A duty of 0 gives buzzer constantly 0 while the counter still runs.
- Valid tone: en == 1 and period >= 2.
- IDLE:
  - buzzer = 0, note_active = 0, cnt held at 0.
  - On a clk edge with a valid tone: latch period_r <= period and duty_r <= duty(period, volume), then go to RUN with cnt = 0.
  - Latency: valid tone sampled at edge t, so buzzer = 1 (if duty_r > 0) and note_active = 1 are visible after edge t.
- RUN:
  - note_active = 1.
  - In each cycle where cnt = k, buzzer = (k < duty_r). buzzer is a registered output, updated at the same edge as cnt.
  - cnt increments by 1 each cycle while cnt < period_r - 1.
- Wrap cycle (cnt == period_r - 1):
  - period_wrap = 1 in this cycle only.
  - At the next edge, en, period and volume are resampled.
  - If the tone is still valid: period_r and duty_r reload, cnt <= 0, stay in RUN (buzzer follows the new duty_r from cnt = 0).
  - Otherwise: go to IDLE, buzzer <= 0, cnt <= 0.
- Changes of en, period or volume between wrap cycles are ignored. The current period always completes in full, with no truncated high pulse.
- A change of period at a wrap that lands on the same value is seamless, with no gap cycle.
- Width rules:
  - cnt is PERIOD_W bits and never exceeds period_r - 1, so it never overflows.
  - The compare period_r - 1 is formed at PERIOD_W bits.
  - period_r >= 2 is guaranteed in RUN.
- Mid-operation reset: rst during RUN forces all reset values at that edge. buzzer is 0 in the following cycle.

Test Plan:
- Basic tone: rst 2 cycles, then en = 1, period = 10, volume = 3 held.
  - Buzzer pattern: 5 high / 5 low, repeating.
  - period_wrap pulses every 10 cycles, coinciding with the 10th (low) cycle.
  - note_active stays 1.
- Boundary change: period = 10, vol 3 running; at cnt = 3 set period = 6.
  - The current period finishes as 5 high / 5 low.
  - Next periods are 3 high / 3 low.
  - No period_wrap pulse until cnt = 9.
- Stop and rest:
  - Deassert en at cnt = 2 of a 10-cycle period: the period completes, then IDLE; buzzer 0 and note_active 0 after the wrap.
  - Separately, en = 1 with period = 0: stays IDLE, buzzer constantly 0.
- Volume / real note: period = 20'hBAA2 (47778, high DO).
  - vol 2: high for 11944 cycles, low for 35834.
  - vol 0: buzzer constantly 0, period_wrap still every 47778 cycles.
  - period = 7, vol 1: duty 0, silent.
- Reset mid-run: rst asserted at cnt = 4 of a 10-cycle tone with buzzer = 1.
  - The next cycle shows buzzer = 0, note_active = 0, period_wrap = 0.
  - After release with the tone still valid, RUN restarts at cnt = 0 after one edge.
- Minimum period: period = 2, vol 3.
  - Buzzer toggles every cycle (1, 0, 1, 0, ...).
  - period_wrap is high on every buzzer = 0 cycle.
